dbus_sramlike_bridge: RTL and testbench
=======================================

// Module: dbus_sramlike_bridge
// PURPOSE
//  Memory-stage data-bus bridge: takes the load/store request the memory stage drives each
//  cycle and runs it as one SRAM-like bus transaction (req/addr_ok/data_ok). Returns load
//  data and d_data_ok, which the hazard unit uses to stall the pipeline until the access ends.
//  Sits between the memory stage and the top-level data SRAM-like port.
// PARAMETERS
//  ADDR_W    32  virtual/physical address width
//  DATA_W    32  data width
//  ADDR_MAP  1   1: kseg0/kseg1 (va[31:30]==2'b10) -> pa = {3'b000, va[28:0]}; 0: pa = va
// PORTS
//  clk          in   1       clock (all state on posedge)
//  reset        in   1       synchronous, active-high
//  m_ren        in   1       memory stage requests a load this cycle
//  m_wen        in   1       memory stage requests a store (m_ren & m_wen never both high)
//  m_addr       in   ADDR_W  virtual address
//  m_size       in   2       0 byte, 1 half, 2 word
//  m_wdata      in   DATA_W  store data, lane-aligned by memory stage
//  flush        in   1       current memory-stage instruction killed (exception/eret)
//  advance      in   1       pipeline moves memory stage forward this cycle (not stallM)
//  rd           out  DATA_W  load data to memory stage; valid while d_data_ok & load
//  d_data_ok    out  1       high when no access is pending for the current instruction
//  data_req     out  1       SRAM-like request
//  data_wr      out  1       1 store, 0 load
//  data_size    out  2       = latched m_size
//  data_addr    out  ADDR_W  physical address
//  data_wdata   out  DATA_W  latched store data
//  data_addr_ok in   1       slave accepts request
//  data_data_ok in   1       load data / store ack
//  data_rdata   in   DATA_W  load data
// BEHAVIOUR
//  Reset: state IDLE; data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, rd=0,
//   cancel flag=0; d_data_ok=1 unless IDLE sees a request that cycle.
//  FSM states IDLE, REQ, WAIT, DONE, DRAIN.
//  IDLE: if (m_ren|m_wen)&!flush: latch wr/size/pa/wdata, go REQ; d_data_ok=0 this cycle.
//   else d_data_ok=1.
//  REQ: data_req=1 with latched fields held stable until addr_ok. addr_ok & data_ok in the
//   same cycle -> DONE (capture rdata). addr_ok only -> WAIT. flush -> set cancel; req stays
//   high (requests are never withdrawn).
//  WAIT: data_req=0; on data_ok capture data_rdata into rd -> DONE (cancel=0) or DRAIN
//   behaviour (cancel=1 -> IDLE, result discarded). flush -> set cancel.
//  DONE: d_data_ok=1, rd stable; stay until advance|flush, then IDLE. No request is issued
//   from DONE, so the instruction still in M is never re-issued.
//  Cancelled access: d_data_ok=0 until data_ok drains it, then IDLE; a new request waits.
//  Latency: min 2 cycles from request to d_data_ok (addr_ok & data_ok in REQ's first cycle).
//  Store completion also goes via data_ok; rd unchanged on stores.
//  Reset mid-transaction: unconditional return to IDLE; no late data_ok is honoured.
//  Only one transaction outstanding at any time.
// STRUCTURE
//  Shared package: dbus_state_t enum, MSIZE_BYTE/HALF/WORD constants, function va2pa().
//  Single module; no sub-module (address map is one function call).
// TESTING
//  Load word va 0xBFC0_0010, addr_ok cycle 1, data_ok cycle 3 rdata 0x1234_5678 ->
//   data_addr 0x1FC0_0010, data_req high 1 cycle, d_data_ok high cycle 4, rd 0x1234_5678.
//  Store byte va 0x8000_0003 wdata 0xAA00_0000, slave addr_ok&data_ok same cycle ->
//   data_wr=1, size=0, addr 0x0000_0003, d_data_ok next cycle, rd unchanged.
//  DONE with advance=0 for 3 cycles -> d_data_ok stays 1, no second data_req pulse; advance=1
//   with next instr a load -> new REQ starts cycle after.
//  flush in WAIT, data_ok 2 cycles later -> d_data_ok=0 throughout, rdata discarded, IDLE.
//  reset asserted in REQ with addr_ok low -> next cycle data_req=0, IDLE, d_data_ok=1.
//  addr_ok held low 10 cycles -> data_req, addr, size, wdata stable all 10 cycles.

Source files
------------

// File: rtl/dbus_sramlike_bridge_pkg.sv
// Shared types and helpers for the memory-stage data-bus bridge: FSM state encoding,
// access-size codes and the kseg0/kseg1 virtual-to-physical address fold.
package dbus_sramlike_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } dbus_state_t;

    localparam logic [1:0] MSIZE_BYTE = 2'd0;
    localparam logic [1:0] MSIZE_HALF = 2'd1;
    localparam logic [1:0] MSIZE_WORD = 2'd2;

    // kseg0/kseg1 share one physical window: drop the top three address bits.
    function automatic logic [31:0] va2pa(input logic [31:0] va, input logic map_en);
        if (map_en && (va[31:30] == 2'b10)) begin
            return {3'b000, va[28:0]};
        end
        return va;
    endfunction

endpackage

// File: rtl/dbus_sramlike_bridge.sv
// Runs each memory-stage load/store as one SRAM-like transaction; min 2 cycles request->d_data_ok.
// Stalls the pipeline via d_data_ok=0; data_req is held until addr_ok and never withdrawn.
module dbus_sramlike_bridge
    import dbus_sramlike_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_MAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_ren,
    input  logic              m_wen,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [1:0]        m_size,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              flush,
    input  logic              advance,
    output logic [DATA_W-1:0] rd,
    output logic              d_data_ok,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dbus_state_t       state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] pa;

    assign pa = ADDR_W'(va2pa(32'(m_addr), ADDR_MAP != 0));

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        cancel_d  = cancel_q;
        data_req  = 1'b0;
        d_data_ok = 1'b0;

        case (state_q)
            IDLE: begin
                if ((m_ren || m_wen) && !flush) begin
                    wr_d     = m_wen;
                    size_d   = m_size;
                    addr_d   = pa;
                    wdata_d  = m_wdata;
                    cancel_d = 1'b0;
                    state_d  = REQ;
                end else begin
                    d_data_ok = 1'b1;
                end
            end
            REQ: begin
                data_req = 1'b1;
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (cancel_d) begin
                            cancel_d = 1'b0;
                            state_d  = IDLE;
                        end else begin
                            if (!wr_q) begin
                                rd_d = data_rdata;
                            end
                            state_d = DONE;
                        end
                    end else begin
                        state_d = cancel_d ? DRAIN : WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                if (data_data_ok) begin
                    if (cancel_d) begin
                        cancel_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        if (!wr_q) begin
                            rd_d = data_rdata;
                        end
                        state_d = DONE;
                    end
                end else if (cancel_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The killed access must still consume its data_ok before a new one may issue.
                if (data_data_ok) begin
                    cancel_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                d_data_ok = 1'b1;
                if (advance || flush) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            cancel_q <= cancel_d;
        end
    end

    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign rd         = rd_q;

endmodule

// File: tb/tb_dbus_sramlike_bridge.sv
// Directed bench for dbus_sramlike_bridge: inputs driven 1 time unit after posedge,
// outputs sampled on the following negedge.
module tb_dbus_sramlike_bridge;

    logic        clk;
    logic        reset;
    logic        m_ren;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    logic [31:0] m_wdata;
    logic        flush;
    logic        advance;
    logic [31:0] rd;
    logic        d_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks;
    int errors;

    dbus_sramlike_bridge #(.ADDR_W(32), .DATA_W(32), .ADDR_MAP(1)) dut (
        .clk(clk), .reset(reset), .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr),
        .m_size(m_size), .m_wdata(m_wdata), .flush(flush), .advance(advance),
        .rd(rd), .d_data_ok(d_data_ok), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_ren = 0; m_wen = 0; m_addr = 0; m_size = 0; m_wdata = 0;
        flush = 0; advance = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        step(); step();
        reset = 0;
        @(negedge clk);
        checks += 7;
        if (data_req !== 1'b0)      begin errors++; $display("FAIL reset_req: got %0h want 0", data_req); end
        if (data_wr !== 1'b0)       begin errors++; $display("FAIL reset_wr: got %0h want 0", data_wr); end
        if (data_size !== 2'd0)     begin errors++; $display("FAIL reset_size: got %0h want 0", data_size); end
        if (data_addr !== 32'h0)    begin errors++; $display("FAIL reset_addr: got %h want 0", data_addr); end
        if (data_wdata !== 32'h0)   begin errors++; $display("FAIL reset_wdata: got %h want 0", data_wdata); end
        if (rd !== 32'h0)           begin errors++; $display("FAIL reset_rd: got %h want 0", rd); end
        if (d_data_ok !== 1'b1)     begin errors++; $display("FAIL reset_dok: got %0h want 1", d_data_ok); end
    endtask

    task automatic test_load_word();
        step(); m_ren = 1; m_addr = 32'hBFC0_0010; m_size = 2'd2;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL lw_c0_dok: got %0h want 0", d_data_ok); end
        step(); data_addr_ok = 1;
        @(negedge clk); checks += 5;
        if (data_req !== 1'b1)          begin errors++; $display("FAIL lw_c1_req: got %0h want 1", data_req); end
        if (data_addr !== 32'h1FC0_0010) begin errors++; $display("FAIL lw_c1_addr: got %h want 1fc00010", data_addr); end
        if (data_wr !== 1'b0)           begin errors++; $display("FAIL lw_c1_wr: got %0h want 0", data_wr); end
        if (data_size !== 2'd2)         begin errors++; $display("FAIL lw_c1_size: got %0h want 2", data_size); end
        if (d_data_ok !== 1'b0)         begin errors++; $display("FAIL lw_c1_dok: got %0h want 0", d_data_ok); end
        step(); data_addr_ok = 0;
        @(negedge clk); checks += 2;
        if (data_req !== 1'b0)  begin errors++; $display("FAIL lw_c2_req: got %0h want 0", data_req); end
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL lw_c2_dok: got %0h want 0", d_data_ok); end
        step(); data_data_ok = 1; data_rdata = 32'h1234_5678;
        @(negedge clk); checks += 2;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL lw_c3_dok: got %0h want 0", d_data_ok); end
        if (data_req !== 1'b0)  begin errors++; $display("FAIL lw_c3_req: got %0h want 0", data_req); end
        step(); data_data_ok = 0; data_rdata = 32'hDEAD_BEEF; m_ren = 0; advance = 1;
        @(negedge clk); checks += 3;
        if (d_data_ok !== 1'b1)      begin errors++; $display("FAIL lw_c4_dok: got %0h want 1", d_data_ok); end
        if (rd !== 32'h1234_5678)    begin errors++; $display("FAIL lw_c4_rd: got %h want 12345678", rd); end
        if (data_req !== 1'b0)       begin errors++; $display("FAIL lw_c4_req: got %0h want 0", data_req); end
        step(); advance = 0;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b1) begin errors++; $display("FAIL lw_c5_idle_dok: got %0h want 1", d_data_ok); end
    endtask

    task automatic test_store_byte();
        step(); m_wen = 1; m_addr = 32'h8000_0003; m_size = 2'd0; m_wdata = 32'hAA00_0000;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL sb_c0_dok: got %0h want 0", d_data_ok); end
        step(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h5555_5555;
        @(negedge clk); checks += 6;
        if (data_req !== 1'b1)          begin errors++; $display("FAIL sb_req: got %0h want 1", data_req); end
        if (data_wr !== 1'b1)           begin errors++; $display("FAIL sb_wr: got %0h want 1", data_wr); end
        if (data_size !== 2'd0)         begin errors++; $display("FAIL sb_size: got %0h want 0", data_size); end
        if (data_addr !== 32'h0000_0003) begin errors++; $display("FAIL sb_addr: got %h want 00000003", data_addr); end
        if (data_wdata !== 32'hAA00_0000) begin errors++; $display("FAIL sb_wdata: got %h want aa000000", data_wdata); end
        if (d_data_ok !== 1'b0)         begin errors++; $display("FAIL sb_c1_dok: got %0h want 0", d_data_ok); end
        step(); data_addr_ok = 0; data_data_ok = 0; advance = 1;
        @(negedge clk); checks += 3;
        if (d_data_ok !== 1'b1)    begin errors++; $display("FAIL sb_c2_dok: got %0h want 1", d_data_ok); end
        if (rd !== 32'h1234_5678)  begin errors++; $display("FAIL sb_rd_kept: got %h want 12345678", rd); end
        if (data_req !== 1'b0)     begin errors++; $display("FAIL sb_c2_req: got %0h want 0", data_req); end
        step(); advance = 0; m_wen = 0;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b1) begin errors++; $display("FAIL sb_c3_idle_dok: got %0h want 1", d_data_ok); end
    endtask

    task automatic test_done_hold();
        int pulses;
        pulses = 0;
        step(); m_ren = 1; m_addr = 32'h0000_0100; m_size = 2'd2;
        step(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
        step(); data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            @(negedge clk); checks += 2;
            if (data_req === 1'b1) pulses++;
            if (d_data_ok !== 1'b1)   begin errors++; $display("FAIL hold_dok[%0d]: got %0h want 1", i, d_data_ok); end
            if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_rd[%0d]: got %h want cafef00d", i, rd); end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL hold_reissue: got %0d req cycles want 0", pulses); end
        step(); advance = 1;
        step(); advance = 0; m_addr = 32'hA000_0040;
        @(negedge clk); checks += 2;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL next_c0_dok: got %0h want 0", d_data_ok); end
        if (data_req !== 1'b0)  begin errors++; $display("FAIL next_c0_req: got %0h want 0", data_req); end
        step(); data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1111_2222;
        @(negedge clk); checks += 2;
        if (data_req !== 1'b1)           begin errors++; $display("FAIL next_req: got %0h want 1", data_req); end
        if (data_addr !== 32'h0000_0040) begin errors++; $display("FAIL next_addr: got %h want 00000040", data_addr); end
        step(); data_addr_ok = 0; data_data_ok = 0; m_ren = 0; advance = 1;
        @(negedge clk); checks++;
        if (rd !== 32'h1111_2222) begin errors++; $display("FAIL next_rd: got %h want 11112222", rd); end
        step(); advance = 0;
    endtask

    task automatic test_flush_wait();
        step(); m_ren = 1; m_addr = 32'h8000_0020; m_size = 2'd2;
        step(); data_addr_ok = 1;
        @(negedge clk); checks++;
        if (data_addr !== 32'h0000_0020) begin errors++; $display("FAIL fl_addr: got %h want 00000020", data_addr); end
        step(); data_addr_ok = 0; flush = 1; m_ren = 0;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL fl_c2_dok: got %0h want 0", d_data_ok); end
        step(); flush = 0;
        @(negedge clk); checks += 2;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL fl_c3_dok: got %0h want 0", d_data_ok); end
        if (data_req !== 1'b0)  begin errors++; $display("FAIL fl_c3_req: got %0h want 0", data_req); end
        step(); data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL fl_c4_dok: got %0h want 0", d_data_ok); end
        step(); data_data_ok = 0; data_rdata = 32'h0;
        @(negedge clk); checks += 3;
        if (d_data_ok !== 1'b1)   begin errors++; $display("FAIL fl_c5_dok: got %0h want 1", d_data_ok); end
        if (rd !== 32'h1111_2222) begin errors++; $display("FAIL fl_discard_rd: got %h want 11112222", rd); end
        if (data_req !== 1'b0)    begin errors++; $display("FAIL fl_c5_req: got %0h want 0", data_req); end
    endtask

    task automatic test_reset_in_req();
        step(); m_ren = 1; m_addr = 32'h0000_0300; m_size = 2'd2;
        step(); reset = 1;
        @(negedge clk); checks++;
        if (data_req !== 1'b1) begin errors++; $display("FAIL rr_req_before: got %0h want 1", data_req); end
        step(); reset = 0; m_ren = 0;
        @(negedge clk); checks += 3;
        if (data_req !== 1'b0)   begin errors++; $display("FAIL rr_req_after: got %0h want 0", data_req); end
        if (d_data_ok !== 1'b1)  begin errors++; $display("FAIL rr_dok: got %0h want 1", d_data_ok); end
        if (data_addr !== 32'h0) begin errors++; $display("FAIL rr_addr: got %h want 0", data_addr); end
        step(); data_data_ok = 1; data_rdata = 32'h7777_7777;
        step(); data_data_ok = 0;
        @(negedge clk); checks += 2;
        if (d_data_ok !== 1'b1) begin errors++; $display("FAIL rr_late_dok: got %0h want 1", d_data_ok); end
        if (rd !== 32'h0)       begin errors++; $display("FAIL rr_late_rd: got %h want 0", rd); end
    endtask

    task automatic test_addr_stall();
        step(); m_wen = 1; m_addr = 32'h9000_1004; m_size = 2'd1; m_wdata = 32'h0000_BEEF;
        for (int i = 0; i < 10; i++) begin
            step(); m_addr = 32'hFFFF_0000 + i; m_wdata = 32'h1234_0000 + i; m_size = 2'd2;
            @(negedge clk); checks += 5;
            if (data_req !== 1'b1)            begin errors++; $display("FAIL st_req[%0d]: got %0h want 1", i, data_req); end
            if (data_addr !== 32'h1000_1004)  begin errors++; $display("FAIL st_addr[%0d]: got %h want 10001004", i, data_addr); end
            if (data_size !== 2'd1)           begin errors++; $display("FAIL st_size[%0d]: got %0h want 1", i, data_size); end
            if (data_wdata !== 32'h0000_BEEF) begin errors++; $display("FAIL st_wdata[%0d]: got %h want 0000beef", i, data_wdata); end
            if (d_data_ok !== 1'b0)           begin errors++; $display("FAIL st_dok[%0d]: got %0h want 0", i, d_data_ok); end
        end
        step(); data_addr_ok = 1;
        step(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h4444_4444;
        @(negedge clk); checks++;
        if (d_data_ok !== 1'b0) begin errors++; $display("FAIL st_wait_dok: got %0h want 0", d_data_ok); end
        step(); data_data_ok = 0; advance = 1;
        @(negedge clk); checks += 2;
        if (d_data_ok !== 1'b1) begin errors++; $display("FAIL st_done_dok: got %0h want 1", d_data_ok); end
        if (rd !== 32'h0)       begin errors++; $display("FAIL st_rd_kept: got %h want 0", rd); end
        step(); advance = 0; m_wen = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_word();
        test_store_byte();
        test_done_hold();
        test_flush_wait();
        test_reset_in_req();
        test_addr_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
